// File: rtl/config_frame_serializer_pkg.sv
// rtl/config_frame_serializer_pkg.sv - shared state enum, default geometry and derived-constant helpers
package config_frame_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SET   = 2'd2,
    DONE  = 2'd3
  } cfs_state_e;

  localparam int CFS_NUM_COLS   = 4;
  localparam int CFS_WORD_W     = 32;
  localparam int CFS_FRAME_BITS = 64;

  // Bits delivered to each column from one input word.
  function automatic int cfs_bpw(input int word_w, input int num_cols);
    return word_w / num_cols;
  endfunction

  function automatic int cfs_wpf(input int frame_bits, input int word_w, input int num_cols);
    return frame_bits / cfs_bpw(word_w, num_cols);
  endfunction

  function automatic int cfs_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/config_frame_serializer_skid.sv
// rtl/config_frame_serializer_skid.sv - cfg_word_skid: one-entry hold register with valid/ready
module cfg_word_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         in_accept,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  logic         hold_vld_q, hold_vld_d;
  logic [W-1:0] hold_data_q, hold_data_d;

  // An accepted word bypasses the hold register when the consumer takes it the same cycle.
  always_comb begin
    in_ready    = en && !hold_vld_q;
    in_accept   = in_valid && in_ready;
    out_valid   = hold_vld_q || in_accept;
    out_data    = hold_vld_q ? hold_data_q : in_data;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (clr) begin
      hold_vld_d  = 1'b0;
      hold_data_d = '0;
    end else if (hold_vld_q && out_ready) begin
      hold_vld_d = 1'b0;
    end else if (in_accept && !out_ready) begin
      hold_vld_d  = 1'b1;
      hold_data_d = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: rtl/config_frame_serializer.sv
// rtl/config_frame_serializer.sv - streams config words into per-column serial chains, then latches them
// Optional checksum output under `define CFG_SER_CHECKSUM_EN.
module config_frame_serializer
  import config_frame_serializer_pkg::*;
#(
  parameter int NUM_COLS   = CFS_NUM_COLS,
  parameter int WORD_W     = CFS_WORD_W,
  parameter int FRAME_BITS = CFS_FRAME_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                word_valid,
  input  logic [WORD_W-1:0]   word_data,
  output logic                word_ready,
  output logic                cen,
  output logic [NUM_COLS-1:0] shift_out,
  output logic [NUM_COLS-1:0] set_out,
  output logic                busy,
  output logic                frame_done
`ifdef CFG_SER_CHECKSUM_EN
  ,
  output logic [WORD_W-1:0]   checksum
`endif
);

  localparam int BPW  = cfs_bpw(WORD_W, NUM_COLS);
  localparam int WPF  = cfs_wpf(FRAME_BITS, WORD_W, NUM_COLS);
  localparam int WC_W = cfs_cnt_w(WPF);
  localparam int BC_W = cfs_cnt_w(FRAME_BITS);
  localparam int BI_W = cfs_cnt_w(BPW - 1);

  localparam logic [WC_W-1:0] WPF_C      = WC_W'(WPF);
  localparam logic [BC_W-1:0] LAST_BEAT  = BC_W'(FRAME_BITS - 1);
  localparam logic [BI_W-1:0] LAST_BIDX  = BI_W'(BPW - 1);

  cfs_state_e        state_q, state_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BI_W-1:0]   bidx_q, bidx_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic              sh_vld_q, sh_vld_d;

  logic              abort_hit;
  logic              beat;
  logic              take;
  logic              skid_en;
  logic              skid_ready;
  logic              skid_accept;
  logic              skid_vld;
  logic [WORD_W-1:0] skid_data;

  assign abort_hit = abort && (state_q != IDLE);
  assign beat      = (state_q == SHIFT) && sh_vld_q;
  // The shift register refills when empty or on the last beat of its word, so words run back-to-back.
  assign take      = (state_q == SHIFT) && (!sh_vld_q || (bidx_q == LAST_BIDX));
  assign skid_en   = (state_q == SHIFT) && (word_cnt_q != WPF_C);

  cfg_word_skid #(
    .W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (abort_hit),
    .en        (skid_en),
    .in_valid  (word_valid),
    .in_data   (word_data),
    .in_ready  (skid_ready),
    .in_accept (skid_accept),
    .out_valid (skid_vld),
    .out_data  (skid_data),
    .out_ready (take)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    beat_cnt_d = beat_cnt_q;
    bidx_d     = bidx_q;
    sh_d       = sh_q;
    sh_vld_d   = sh_vld_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = SHIFT;
          word_cnt_d = '0;
          beat_cnt_d = '0;
          bidx_d     = '0;
        end
      end
      SHIFT: begin
        if (skid_accept) begin
          word_cnt_d = word_cnt_q + 1'b1;
        end
        if (beat) begin
          sh_d       = sh_q >> NUM_COLS;
          bidx_d     = bidx_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            state_d = SET;
          end
        end
        if (take) begin
          sh_vld_d = skid_vld;
          sh_d     = skid_vld ? skid_data : '0;
          bidx_d   = '0;
        end
      end
      SET:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_hit) begin
      state_d    = IDLE;
      word_cnt_d = '0;
      beat_cnt_d = '0;
      bidx_d     = '0;
      sh_d       = '0;
      sh_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      beat_cnt_q <= '0;
      bidx_q     <= '0;
      sh_q       <= '0;
      sh_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      bidx_q     <= bidx_d;
      sh_q       <= sh_d;
      sh_vld_q   <= sh_vld_d;
    end
  end

  // Outputs depend only on flops, so they all drop to zero the instant reset asserts.
  always_comb begin
    word_ready = skid_ready;
    cen        = beat || (state_q == SET);
    shift_out  = beat ? sh_q[NUM_COLS-1:0] : '0;
    set_out    = {NUM_COLS{state_q == SET}};
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
  end

`ifdef CFG_SER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == IDLE) && start && !abort) begin
      csum_d = '0;
    end else if (skid_accept) begin
      csum_d = csum_q ^ word_data;
    end
    if (abort_hit) begin
      csum_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule
